// File: rtl/instr_cache_refill_pkg.sv
// Shared icache geometry, tag-entry layout, refill state encoding and the
// address slicing helpers used by both the tag stage and the refill engine.
package instr_cache_refill_pkg;

    localparam int unsigned ICACHE_PADDR_WIDTH = 32;
    localparam int unsigned ICACHE_LINE_BYTES  = 64;
    localparam int unsigned ICACHE_BEAT_WIDTH  = 64;
    localparam int unsigned ICACHE_SETS        = 64;

    localparam int unsigned ICACHE_OFS_BITS  = $clog2(ICACHE_LINE_BYTES);
    localparam int unsigned ICACHE_SET_BITS  = $clog2(ICACHE_SETS);
    localparam int unsigned ICACHE_TAG_BITS  = ICACHE_PADDR_WIDTH - ICACHE_SET_BITS - ICACHE_OFS_BITS;
    localparam int unsigned ICACHE_BEATS     = (ICACHE_LINE_BYTES * 8) / ICACHE_BEAT_WIDTH;
    localparam int unsigned ICACHE_BEAT_BITS = $clog2(ICACHE_BEATS);

    typedef struct packed {
        logic                       valid;
        logic [ICACHE_TAG_BITS-1:0] tag;
    } icache_tag_entry_t;

    typedef enum logic [2:0] {
        RS_IDLE  = 3'd0,
        RS_REQ   = 3'd1,
        RS_FILL  = 3'd2,
        RS_TAG   = 3'd3,
        RS_DRAIN = 3'd4
    } icache_refill_state_t;

    // Set index of a physical address.
    function automatic logic [ICACHE_SET_BITS-1:0] icache_set(
        input logic [ICACHE_PADDR_WIDTH-1:0] paddr
    );
        return ICACHE_SET_BITS'(paddr >> ICACHE_OFS_BITS);
    endfunction

    // Tag field of a physical address.
    function automatic logic [ICACHE_TAG_BITS-1:0] icache_tag(
        input logic [ICACHE_PADDR_WIDTH-1:0] paddr
    );
        return ICACHE_TAG_BITS'(paddr >> (ICACHE_SET_BITS + ICACHE_OFS_BITS));
    endfunction

endpackage

// File: rtl/instr_cache_refill.sv
// Instruction-cache miss handler: takes one miss, issues one line read,
// streams the returned beats into the data array, then installs the tag.
module instr_cache_refill
    import instr_cache_refill_pkg::*;
#(
    parameter int unsigned PADDR_WIDTH = ICACHE_PADDR_WIDTH,
    parameter int unsigned LINE_BYTES  = ICACHE_LINE_BYTES,
    parameter int unsigned BEAT_WIDTH  = ICACHE_BEAT_WIDTH,
    parameter int unsigned SETS        = ICACHE_SETS
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_flush,
    input  logic                        i_miss_valid,
    input  logic [PADDR_WIDTH-1:0]      i_miss_paddr,
    output logic                        o_miss_ready,
    output logic                        o_mem_req_valid,
    output logic [PADDR_WIDTH-1:0]      o_mem_req_addr,
    input  logic                        i_mem_req_ready,
    input  logic                        i_mem_resp_valid,
    input  logic [BEAT_WIDTH-1:0]       i_mem_resp_data,
    output logic                        o_data_we,
    output logic [ICACHE_SET_BITS-1:0]  o_data_set,
    output logic [ICACHE_BEAT_BITS-1:0] o_data_beat,
    output logic [BEAT_WIDTH-1:0]       o_data_wdata,
    output logic                        o_tag_we,
    output logic [ICACHE_SET_BITS-1:0]  o_tag_set,
    output icache_tag_entry_t           o_tag,
    output logic                        o_refill_done,
    input  logic [31:0]                 i_log_fd
);

    localparam int unsigned BEATS     = (LINE_BYTES * 8) / BEAT_WIDTH;
    localparam int unsigned BEAT_BITS = $clog2(BEATS);

    localparam logic [PADDR_WIDTH-1:0] OFS_MASK  = PADDR_WIDTH'(LINE_BYTES - 1);
    localparam logic [BEAT_BITS-1:0]   LAST_BEAT = BEAT_BITS'(BEATS - 1);

    // Port widths and the tag-entry layout come from the package geometry.
    if (PADDR_WIDTH != ICACHE_PADDR_WIDTH || LINE_BYTES != ICACHE_LINE_BYTES ||
        BEAT_WIDTH != ICACHE_BEAT_WIDTH || SETS != ICACHE_SETS) begin : g_param_check
        $error("instr_cache_refill: parameters must match instr_cache_refill_pkg geometry");
    end

    icache_refill_state_t   state_q;
    logic [BEAT_BITS-1:0]   cnt_q;
    logic [PADDR_WIDTH-1:0] addr_q;

    logic miss_accept;
    logic beat_last;

    // The log descriptor is consumed by the simulation-side monitor only.
    logic unused_log_fd;
    assign unused_log_fd = ^i_log_fd;

    assign miss_accept = (state_q == RS_IDLE) && !i_flush && i_miss_valid;
    assign beat_last   = i_mem_resp_valid && (cnt_q == LAST_BEAT);

    // State, beat counter and line address.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= RS_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
        end else begin
            case (state_q)
                RS_IDLE: begin
                    if (miss_accept) begin
                        addr_q  <= i_miss_paddr & ~OFS_MASK;
                        state_q <= RS_REQ;
                    end
                end
                RS_REQ: begin
                    if (i_mem_req_ready) begin
                        cnt_q   <= '0;
                        state_q <= i_flush ? RS_DRAIN : RS_FILL;
                    end else if (i_flush) begin
                        state_q <= RS_IDLE;
                    end
                end
                RS_FILL: begin
                    if (i_mem_resp_valid) begin
                        cnt_q <= cnt_q + BEAT_BITS'(1);
                    end
                    // A flush on the final beat leaves nothing to drain.
                    if (beat_last) begin
                        state_q <= i_flush ? RS_IDLE : RS_TAG;
                    end else if (i_flush) begin
                        state_q <= RS_DRAIN;
                    end
                end
                RS_DRAIN: begin
                    if (i_mem_resp_valid) begin
                        cnt_q <= cnt_q + BEAT_BITS'(1);
                    end
                    if (beat_last) begin
                        state_q <= RS_IDLE;
                    end
                end
                RS_TAG: begin
                    state_q <= RS_IDLE;
                end
                default: begin
                    state_q <= RS_IDLE;
                end
            endcase
        end
    end

    // Array strobes and handshakes decoded from the registered state.
    always_comb begin
        o_miss_ready    = 1'b0;
        o_mem_req_valid = 1'b0;
        o_data_we       = 1'b0;
        o_tag_we        = 1'b0;
        o_refill_done   = 1'b0;
        case (state_q)
            RS_IDLE: o_miss_ready    = !i_flush;
            RS_REQ:  o_mem_req_valid = 1'b1;
            RS_FILL: o_data_we       = i_mem_resp_valid && !i_flush;
            RS_TAG: begin
                o_tag_we      = !i_flush;
                o_refill_done = !i_flush;
            end
            default: ;
        endcase
    end

    assign o_mem_req_addr = addr_q;
    assign o_data_set     = icache_set(addr_q);
    assign o_data_beat    = cnt_q;
    assign o_data_wdata   = i_mem_resp_data;
    assign o_tag_set      = icache_set(addr_q);
    assign o_tag.valid    = 1'b1;
    assign o_tag.tag      = icache_tag(addr_q);

endmodule

// File: tb/tb_instr_cache_refill.sv
// Directed bench for instr_cache_refill: hand-computed vectors, immediate
// assertions at every comparison point.
module tb_instr_cache_refill;
    import instr_cache_refill_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        miss_valid = 1'b0;
    logic [31:0] miss_paddr = '0;
    logic        miss_ready;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready = 1'b0;
    logic        resp_valid = 1'b0;
    logic [63:0] resp_data = '0;
    logic        data_we;
    logic [5:0]  data_set;
    logic [2:0]  data_beat;
    logic [63:0] data_wdata;
    logic        tag_we;
    logic [5:0]  tag_set;
    icache_tag_entry_t tag;
    logic        refill_done;
    logic [31:0] log_fd = '0;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    instr_cache_refill dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_flush          (flush),
        .i_miss_valid     (miss_valid),
        .i_miss_paddr     (miss_paddr),
        .o_miss_ready     (miss_ready),
        .o_mem_req_valid  (mem_req_valid),
        .o_mem_req_addr   (mem_req_addr),
        .i_mem_req_ready  (mem_req_ready),
        .i_mem_resp_valid (resp_valid),
        .i_mem_resp_data  (resp_data),
        .o_data_we        (data_we),
        .o_data_set       (data_set),
        .o_data_beat      (data_beat),
        .o_data_wdata     (data_wdata),
        .o_tag_we         (tag_we),
        .o_tag_set        (tag_set),
        .o_tag            (tag),
        .o_refill_done    (refill_done),
        .i_log_fd         (log_fd)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    // Present a miss for one cycle and expect it to be taken.
    task automatic accept_miss(input logic [31:0] paddr);
        tick();
        miss_valid = 1'b1;
        miss_paddr = paddr;
        settle();
        check("accept_ready", 64'(miss_ready), 64'd1);
        tick();
        miss_valid = 1'b0;
    endtask

    // One response beat during FILL/DRAIN.
    task automatic beat(input string name, input int b, input logic fl,
                        input logic exp_we, input logic [5:0] exp_set);
        tick();
        mem_req_ready = 1'b0;
        resp_valid    = 1'b1;
        resp_data     = 64'hC0DE_0000_0000_0000 | 64'(b);
        flush         = fl;
        settle();
        check({name, "_we"}, 64'(data_we), 64'(exp_we));
        check({name, "_ready"}, 64'(miss_ready), 64'd0);
        if (exp_we) begin
            check({name, "_beat"}, 64'(data_beat), 64'(b));
            check({name, "_set"}, 64'(data_set), 64'(exp_set));
            check({name, "_wdata"}, data_wdata, 64'hC0DE_0000_0000_0000 | 64'(b));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset
        tick();
        tick();
        rst_n = 1'b1;
        settle();
        check("rst_miss_ready", 64'(miss_ready), 64'd1);
        check("rst_req_valid", 64'(mem_req_valid), 64'd0);
        check("rst_req_addr", 64'(mem_req_addr), 64'd0);
        check("rst_data_we", 64'(data_we), 64'd0);
        check("rst_tag_we", 64'(tag_we), 64'd0);
        check("rst_done", 64'(refill_done), 64'd0);

        // Basic refill: 0x1234 -> line 0x1200, set 0x08, tag 0x00001
        accept_miss(32'h0000_1234);
        mem_req_ready = 1'b1;
        settle();
        check("basic_req_valid", 64'(mem_req_valid), 64'd1);
        check("basic_req_addr", 64'(mem_req_addr), 64'h1200);
        check("basic_busy", 64'(miss_ready), 64'd0);
        for (int b = 0; b < 8; b++) beat("basic_beat", b, 1'b0, 1'b1, 6'h08);
        tick();
        resp_valid = 1'b0;
        settle();
        check("basic_tag_we", 64'(tag_we), 64'd1);
        check("basic_done", 64'(refill_done), 64'd1);
        check("basic_tag_set", 64'(tag_set), 64'h08);
        check("basic_tag", 64'(tag), 64'h10_0001);
        tick();
        settle();
        check("basic_idle_ready", 64'(miss_ready), 64'd1);
        check("basic_tag_we_off", 64'(tag_we), 64'd0);

        // Request backpressure: 0x45678 -> line 0x45640, set 0x19, tag 0x45
        accept_miss(32'h0004_5678);
        for (int i = 0; i < 5; i++) begin
            settle();
            check("bp_req_valid", 64'(mem_req_valid), 64'd1);
            check("bp_req_addr", 64'(mem_req_addr), 64'h4_5640);
            tick();
        end
        mem_req_ready = 1'b1;
        settle();
        check("bp_req_valid_hs", 64'(mem_req_valid), 64'd1);
        for (int b = 0; b < 8; b++) beat("bp_beat", b, 1'b0, 1'b1, 6'h19);
        tick();
        resp_valid = 1'b0;
        settle();
        check("bp_tag_we", 64'(tag_we), 64'd1);
        check("bp_tag", 64'(tag), 64'h10_0045);

        // Beat gaps: 0xDEADBEEF -> set 0x3B, tag 0xDEADB
        accept_miss(32'hDEAD_BEEF);
        mem_req_ready = 1'b1;
        settle();
        check("gap_req_addr", 64'(mem_req_addr), 64'hDEAD_BEC0);
        for (int b = 0; b < 8; b++) begin
            beat("gap_beat", b, 1'b0, 1'b1, 6'h3B);
            if (b < 7) begin
                tick();
                resp_valid = 1'b0;
                settle();
                check("gap_idle_we", 64'(data_we), 64'd0);
                check("gap_idle_tag_we", 64'(tag_we), 64'd0);
            end
        end
        tick();
        resp_valid = 1'b0;
        settle();
        check("gap_tag_we", 64'(tag_we), 64'd1);
        check("gap_tag", 64'(tag), 64'h1D_EADB);
        check("gap_tag_set", 64'(tag_set), 64'h3B);

        // Flush in REQ before ready, then flush+miss in IDLE
        accept_miss(32'h0000_2000);
        flush = 1'b1;
        settle();
        check("freq_busy", 64'(miss_ready), 64'd0);
        tick();
        flush      = 1'b1;
        miss_valid = 1'b1;
        miss_paddr = 32'h0000_7000;
        settle();
        check("freq_idle_req_valid", 64'(mem_req_valid), 64'd0);
        check("fidle_ready_low", 64'(miss_ready), 64'd0);
        tick();
        flush      = 1'b0;
        miss_valid = 1'b0;
        settle();
        check("fidle_not_accepted", 64'(mem_req_valid), 64'd0);
        check("fidle_ready", 64'(miss_ready), 64'd1);

        // Flush after beat 3: beats 4..7 drained without writes
        accept_miss(32'h0000_3040);
        mem_req_ready = 1'b1;
        for (int b = 0; b < 4; b++) beat("fl_beat", b, 1'b0, 1'b1, 6'h01);
        beat("fl_flush_beat", 4, 1'b1, 1'b0, 6'h01);
        miss_valid = 1'b1;
        miss_paddr = 32'h0000_9000;
        for (int b = 5; b < 8; b++) begin
            beat("fl_drain", b, 1'b0, 1'b0, 6'h01);
            check("fl_drain_tag_we", 64'(tag_we), 64'd0);
        end
        tick();
        resp_valid = 1'b0;
        miss_valid = 1'b0;
        settle();
        check("fl_after_ready", 64'(miss_ready), 64'd1);
        check("fl_after_tag_we", 64'(tag_we), 64'd0);
        check("fl_after_done", 64'(refill_done), 64'd0);

        // Flush coincident with TAG
        accept_miss(32'h0000_5000);
        mem_req_ready = 1'b1;
        for (int b = 0; b < 8; b++) beat("ft_beat", b, 1'b0, 1'b1, 6'h00);
        tick();
        resp_valid = 1'b0;
        flush      = 1'b1;
        settle();
        check("ft_tag_we", 64'(tag_we), 64'd0);
        check("ft_done", 64'(refill_done), 64'd0);
        tick();
        flush = 1'b0;
        settle();
        check("ft_idle_ready", 64'(miss_ready), 64'd1);
        check("ft_idle_tag_we", 64'(tag_we), 64'd0);

        // Reset asserted in FILL
        accept_miss(32'h0000_6000);
        mem_req_ready = 1'b1;
        for (int b = 0; b < 3; b++) beat("rf_beat", b, 1'b0, 1'b1, 6'h00);
        tick();
        rst_n      = 1'b0;
        resp_valid = 1'b0;
        tick();
        rst_n      = 1'b1;
        resp_valid = 1'b1;
        settle();
        check("rf_miss_ready", 64'(miss_ready), 64'd1);
        check("rf_req_valid", 64'(mem_req_valid), 64'd0);
        check("rf_req_addr", 64'(mem_req_addr), 64'd0);
        check("rf_data_we", 64'(data_we), 64'd0);
        check("rf_tag_we", 64'(tag_we), 64'd0);
        check("rf_done", 64'(refill_done), 64'd0);
        tick();
        resp_valid = 1'b0;
        settle();
        check("rf_still_idle", 64'(miss_ready), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
